lock_and_count_ex: RTL and testbench

- Parametrised successor to the two-input interval counter.
- Measures the signed number of clocks between the first rising edge on in_a and on in_b after an explicit arm.
- Saturates at a programmable limit and presents the result through a valid/ack hold register.
- Sits between the comparator/discriminator front end and the frequency/phase readout logic; one instance per channel pair.

---
 rtl/lock_and_count_ex.sv | 171 +++++++++++++++++
 tb/tb_lock_and_count_ex.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_and_count_ex.sv
// Signed A-to-B interval counter with saturation and a valid/ack result register.
// Optional macro LOCK_AND_COUNT_AUTO_REARM_EN: ack in DONE re-arms directly instead of returning to IDLE.
module lock_and_count_ex #(
  parameter int WIDTH       = 26,
  parameter int LIMIT       = 24999999,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    in_a,
  input  logic                    in_b,
  input  logic                    arm,
  input  logic                    ack,
  output logic signed [WIDTH-1:0] result,
  output logic                    valid,
  output logic                    overflow,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_U  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIMIT_M1 = WIDTH'(LIMIT - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("lock_and_count_ex: SYNC_STAGES must be in 2..4");
  end
  if (LIMIT < 1 || longint'(LIMIT) > ((longint'(1) << (WIDTH - 1)) - 1)) begin : g_bad_limit
    $error("lock_and_count_ex: LIMIT must be in 1..2^(WIDTH-1)-1");
  end

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0]  sync_b_q, sync_b_d;
  logic                    prev_a_q, prev_a_d;
  logic                    prev_b_q, prev_b_d;
  logic                    ea_q, ea_d;
  logic                    eb_q, eb_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    sign_q, sign_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    busy_q, busy_d;
  logic                    opp_edge;

  // Handshake: valid rises on entry to DONE and holds result/overflow frozen;
  // the consumer pulses ack while valid=1 and valid falls on that same clock edge.

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] mag);
    apply_sign = neg ? (~mag + {{(WIDTH-1){1'b0}}, 1'b1}) : mag;
  endfunction

  // Both channels share the same synchroniser depth and edge register, so no relative skew.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], in_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], in_b};
    prev_a_d = sync_a_q[SYNC_STAGES-1];
    prev_b_d = sync_b_q[SYNC_STAGES-1];
    ea_d     = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
    eb_d     = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    opp_edge   = sign_q ? ea_q : eb_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (ea_q && eb_q) begin
          state_d    = ST_DONE;
          result_d   = '0;
          overflow_d = 1'b0;
          valid_d    = 1'b1;
        end else if (ea_q) begin
          state_d = ST_COUNT;
          sign_d  = 1'b0;
          cnt_d   = '0;
        end else if (eb_q) begin
          state_d = ST_COUNT;
          sign_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        // cnt_q holds N-1 in the cycle N clocks after the first edge.
        if (opp_edge) begin
          state_d    = ST_DONE;
          result_d   = apply_sign(sign_q, cnt_q + {{(WIDTH-1){1'b0}}, 1'b1});
          overflow_d = 1'b0;
          valid_d    = 1'b1;
        end else if (cnt_q == LIMIT_M1) begin
          state_d    = ST_DONE;
          result_d   = apply_sign(sign_q, LIMIT_U);
          overflow_d = 1'b1;
          valid_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (ack) begin
          valid_d = 1'b0;
`ifdef LOCK_AND_COUNT_AUTO_REARM_EN
          state_d = ST_ARMED;
          cnt_d   = '0;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ARMED) || (state_d == ST_COUNT);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      prev_a_q   <= 1'b0;
      prev_b_q   <= 1'b0;
      ea_q       <= 1'b0;
      eb_q       <= 1'b0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      prev_a_q   <= prev_a_d;
      prev_b_q   <= prev_b_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = $signed(result_q);
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lock_and_count_ex.sv
// Directed bench for lock_and_count_ex: vector table of measurements plus hand-written corner sequences.
module tb_lock_and_count_ex;

  localparam int W   = 26;
  localparam int LIM = 1000;
  localparam int SS  = 2;

  logic                clk = 1'b0;
  logic                clrn;
  logic                in_a;
  logic                in_b;
  logic                arm;
  logic                ack;
  logic signed [W-1:0] result;
  logic                valid;
  logic                overflow;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  lock_and_count_ex #(.WIDTH(W), .LIMIT(LIM), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .in_a     (in_a),
    .in_b     (in_b),
    .arm      (arm),
    .ack      (ack),
    .result   (result),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // lead: 0 A leads B by gap, 1 B leads A by gap, 2 both together, 3 A only, 4 B only
  typedef struct {
    int     lead;
    int     gap;
    longint exp_res;
    logic   exp_ovf;
    int     exp_lat;
  } vec_t;

  vec_t vecs[8];

`ifdef LOCK_AND_COUNT_AUTO_REARM_EN
  localparam int  AFTER_ACK_STATE = 1;
  localparam logic AFTER_ACK_BUSY = 1'b1;
`else
  localparam int  AFTER_ACK_STATE = 0;
  localparam logic AFTER_ACK_BUSY = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Raises the leading input(s), the trailing input gap clocks later, and
  // returns the number of clocks from the first rise until valid is seen.
  task automatic measure(input int lead, input int gap, output int lat);
    int n;
    bit second;
    lat = -1;
    case (lead)
      0: in_a = 1'b1;
      1: in_b = 1'b1;
      2: begin in_a = 1'b1; in_b = 1'b1; end
      3: in_a = 1'b1;
      default: in_b = 1'b1;
    endcase
    second = (lead == 0) || (lead == 1);
    n = 0;
    while (n < LIM + 100) begin
      step();
      n++;
      if (valid) begin
        lat = n;
        break;
      end
      if (second && n == gap) begin
        if (lead == 0) in_b = 1'b1;
        else           in_a = 1'b1;
      end
    end
    in_a = 1'b0;
    in_b = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, AFTER_ACK_BUSY);
    chk("ack_state", int'(dut.state_q), AFTER_ACK_STATE);
    step();
  endtask

  initial begin
    int lat;
    int seen;

    clrn = 1'b0;
    in_a = 1'b0;
    in_b = 1'b0;
    arm  = 1'b0;
    ack  = 1'b0;

    vecs[0] = '{0, 100,  100, 1'b0,  104};
    vecs[1] = '{1, 37,   -37, 1'b0,  41};
    vecs[2] = '{2, 0,    0,   1'b0,  4};
    vecs[3] = '{3, 0,    1000, 1'b1, LIM + 4};
    vecs[4] = '{4, 0,   -1000, 1'b1, LIM + 4};
    vecs[5] = '{0, 1,    1,   1'b0,  5};
    vecs[6] = '{1, 1,   -1,   1'b0,  5};
    vecs[7] = '{0, 1000, 1000, 1'b0, LIM + 4};

    repeat (3) step();
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", int'(dut.state_q), 0);
    clrn = 1'b1;
    step();

`ifdef LOCK_AND_COUNT_AUTO_REARM_EN
    do_arm();
    chk("rearm_busy", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      measure(0, 5 * i, lat);
      chk("rearm_lat", lat, 5 * i + 4);
      chk("rearm_result", result, 5 * i);
      chk("rearm_ovf", overflow, 0);
      do_ack();
    end
`else
    // Edges in IDLE must not start anything.
    in_a = 1'b1; in_b = 1'b1;
    repeat (3) step();
    in_a = 1'b0; in_b = 1'b0;
    repeat (3) step();
    in_a = 1'b1;
    repeat (3) step();
    in_a = 1'b0;
    repeat (8) step();
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_state", int'(dut.state_q), 0);

    for (int i = 0; i < 8; i++) begin
      do_arm();
      chk("vec_busy_armed", busy, 1);
      step();
      measure(vecs[i].lead, vecs[i].gap, lat);
      chk("vec_latency", lat, vecs[i].exp_lat);
      chk("vec_result", result, vecs[i].exp_res);
      chk("vec_overflow", overflow, vecs[i].exp_ovf);
      chk("vec_valid", valid, 1);
      chk("vec_busy_done", busy, 0);
      do_ack();
    end

    // Result must hold while unacknowledged; stray ack-free cycles change nothing.
    do_arm();
    step();
    measure(1, 37, lat);
    chk("hold_result0", result, -37);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("hold_result", result, -37);
      chk("hold_valid", valid, 1);
    end
    chk("hold_ovf", overflow, 0);
    do_ack();

    // Arm while valid=0 in IDLE then ack with nothing pending: ack ignored.
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("stray_ack_state", int'(dut.state_q), 0);

    // Repeat pulses on the leading channel during COUNT are ignored.
    do_arm();
    step();
    in_a = 1'b1;
    lat = -1;
    for (int n = 1; n <= 80; n++) begin
      step();
      if (valid && lat < 0) lat = n;
      if (n == 3)  in_a = 1'b0;
      if (n == 10) in_a = 1'b1;
      if (n == 15) in_a = 1'b0;
      if (n == 30) in_b = 1'b1;
    end
    in_b = 1'b0;
    chk("repeat_lat", lat, 34);
    chk("repeat_result", result, 30);
    chk("repeat_ovf", overflow, 0);
    do_ack();

    // Reset in COUNT aborts silently.
    do_arm();
    step();
    in_a = 1'b1;
    repeat (20) step();
    chk("abort_busy_pre", busy, 1);
    clrn = 1'b0;
    #2;
    chk("abort_result", result, 0);
    chk("abort_valid", valid, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_busy", busy, 0);
    repeat (3) step();
    clrn = 1'b1;
    step();
    in_b = 1'b1;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_state", int'(dut.state_q), 0);
    in_a = 1'b0;
    in_b = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
